// File: rtl/multicycle_control.sv
// Control FSM for the multi-cycle MIPS-subset CPU: sequences IF/ID/EXE/MEM/WB
// and decodes ALU/datapath selects from op/funct.
module multicycle_control #(
  parameter logic [5:0] HALT_OP    = 6'b111111,
  parameter logic [1:0] RA_REG_SEL = 2'b00
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  input  logic       zero_i,
  output logic       pc_wre_o,
  output logic       ir_wre_o,
  output logic       ins_mem_rw_o,
  output logic       alu_src_a_o,
  output logic       alu_src_b_o,
  output logic [2:0] alu_ctr_o,
  output logic       ext_sel_o,
  output logic       reg_wre_o,
  output logic [1:0] reg_dst_o,
  output logic       wr_reg_d_src_o,
  output logic       db_data_src_o,
  output logic       m_rd_o,
  output logic       m_wr_o,
  output logic [1:0] pc_src_o,
  output logic       illegal_op_o,
  output logic [2:0] state_o
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_JR  = 6'b001000;

  // Bit 3 is the halt flag; the debug port shows only the low three bits.
  typedef enum logic [3:0] {
    S_IF     = 4'b0000,
    S_ID     = 4'b0001,
    S_EXE_LS = 4'b0010,
    S_MEM    = 4'b0011,
    S_WB_L   = 4'b0100,
    S_EXE_BR = 4'b0101,
    S_EXE_AL = 4'b0110,
    S_WB_AL  = 4'b0111,
    S_HALT   = 4'b1000
  } state_e;

  typedef enum logic [2:0] {
    C_ALU, C_LW, C_SW, C_BR, C_JMP, C_JAL, C_HALT, C_ILL
  } cls_e;

  state_e state_q, state_d;
  cls_e   cls;
  logic   is_rtype;

  // Instruction decode: class plus state-independent datapath selects.
  always_comb begin
    cls         = C_ILL;
    alu_ctr_o   = 3'b000;
    alu_src_a_o = 1'b0;
    alu_src_b_o = 1'b0;
    ext_sel_o   = 1'b1;
    pc_src_o    = 2'b00;
    is_rtype    = (op_i == OP_RTYPE);
    case (op_i)
      OP_RTYPE: begin
        case (funct_i)
          FN_ADD: cls = C_ALU;
          FN_SUB: begin cls = C_ALU; alu_ctr_o = 3'b001; end
          FN_AND: begin cls = C_ALU; alu_ctr_o = 3'b010; end
          FN_OR:  begin cls = C_ALU; alu_ctr_o = 3'b011; end
          FN_SLT: begin cls = C_ALU; alu_ctr_o = 3'b101; end
          FN_SLL: begin cls = C_ALU; alu_ctr_o = 3'b100; alu_src_a_o = 1'b1; end
          FN_JR:  begin cls = C_JMP; pc_src_o = 2'b10; end
          default: cls = C_ILL;
        endcase
      end
      OP_ADDIU: begin cls = C_ALU; alu_src_b_o = 1'b1; end
      OP_ANDI:  begin cls = C_ALU; alu_src_b_o = 1'b1; alu_ctr_o = 3'b010; ext_sel_o = 1'b0; end
      OP_ORI:   begin cls = C_ALU; alu_src_b_o = 1'b1; alu_ctr_o = 3'b011; ext_sel_o = 1'b0; end
      OP_XORI:  begin cls = C_ALU; alu_src_b_o = 1'b1; alu_ctr_o = 3'b111; ext_sel_o = 1'b0; end
      OP_SLTI:  begin cls = C_ALU; alu_src_b_o = 1'b1; alu_ctr_o = 3'b101; end
      OP_LW:    begin cls = C_LW;  alu_src_b_o = 1'b1; end
      OP_SW:    begin cls = C_SW;  alu_src_b_o = 1'b1; end
      OP_BEQ:   begin cls = C_BR;  alu_ctr_o = 3'b001; pc_src_o = zero_i ? 2'b01 : 2'b00; end
      OP_BNE:   begin cls = C_BR;  alu_ctr_o = 3'b001; pc_src_o = zero_i ? 2'b00 : 2'b01; end
      OP_J:     begin cls = C_JMP; pc_src_o = 2'b11; end
      OP_JAL:   begin cls = C_JAL; pc_src_o = 2'b11; end
      HALT_OP:  cls = C_HALT;
      default:  cls = C_ILL;
    endcase
  end

  // Next state and per-state enables; reset masks every write-side enable.
  always_comb begin
    state_d        = state_q;
    pc_wre_o       = 1'b0;
    ir_wre_o       = 1'b0;
    ins_mem_rw_o   = 1'b0;
    reg_wre_o      = 1'b0;
    reg_dst_o      = 2'b00;
    wr_reg_d_src_o = 1'b0;
    db_data_src_o  = 1'b0;
    m_rd_o         = 1'b0;
    m_wr_o         = 1'b0;
    illegal_op_o   = 1'b0;
    case (state_q)
      S_IF: begin
        ins_mem_rw_o = 1'b1;
        ir_wre_o     = 1'b1;
        state_d      = S_ID;
      end
      S_ID: begin
        case (cls)
          C_ALU:       state_d = S_EXE_AL;
          C_LW, C_SW:  state_d = S_EXE_LS;
          C_BR:        state_d = S_EXE_BR;
          C_HALT:      state_d = S_HALT;
          C_JMP: begin pc_wre_o = 1'b1; state_d = S_IF; end
          C_JAL: begin
            pc_wre_o       = 1'b1;
            reg_wre_o      = 1'b1;
            reg_dst_o      = RA_REG_SEL;
            wr_reg_d_src_o = 1'b0;
            state_d        = S_IF;
          end
          default: begin illegal_op_o = 1'b1; pc_wre_o = 1'b1; state_d = S_IF; end
        endcase
      end
      S_EXE_AL: state_d = S_WB_AL;
      S_WB_AL: begin
        reg_wre_o      = 1'b1;
        reg_dst_o      = is_rtype ? 2'b10 : 2'b01;
        wr_reg_d_src_o = 1'b1;
        pc_wre_o       = 1'b1;
        state_d        = S_IF;
      end
      S_EXE_LS: state_d = S_MEM;
      S_MEM: begin
        if (cls == C_LW) begin
          m_rd_o  = 1'b1;
          state_d = S_WB_L;
        end else begin
          m_wr_o   = 1'b1;
          pc_wre_o = 1'b1;
          state_d  = S_IF;
        end
      end
      S_WB_L: begin
        reg_wre_o      = 1'b1;
        reg_dst_o      = 2'b01;
        wr_reg_d_src_o = 1'b1;
        db_data_src_o  = 1'b1;
        pc_wre_o       = 1'b1;
        state_d        = S_IF;
      end
      S_EXE_BR: begin pc_wre_o = 1'b1; state_d = S_IF; end
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IF;
    endcase
    if (!rst_ni) begin
      state_d      = S_IF;
      pc_wre_o     = 1'b0;
      ir_wre_o     = 1'b0;
      reg_wre_o    = 1'b0;
      m_wr_o       = 1'b0;
      m_rd_o       = 1'b0;
      illegal_op_o = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= S_IF;
    else         state_q <= state_d;
  end

  assign state_o = state_q[2:0];

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed and randomized instructions checked
// against an instruction-level model of paths and per-cycle controls.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] op, funct;
  logic       zero;
  logic       pc_wre, ir_wre, ins_mem_rw, alu_src_a, alu_src_b, ext_sel;
  logic       reg_wre, wr_reg_d_src, db_data_src, m_rd, m_wr, illegal_op;
  logic [2:0] alu_ctr, state;
  logic [1:0] reg_dst, pc_src;

  int checks = 0;
  int failures = 0;

  multicycle_control dut (
    .clk_i(clk), .rst_ni(rst_n), .op_i(op), .funct_i(funct), .zero_i(zero),
    .pc_wre_o(pc_wre), .ir_wre_o(ir_wre), .ins_mem_rw_o(ins_mem_rw),
    .alu_src_a_o(alu_src_a), .alu_src_b_o(alu_src_b), .alu_ctr_o(alu_ctr),
    .ext_sel_o(ext_sel), .reg_wre_o(reg_wre), .reg_dst_o(reg_dst),
    .wr_reg_d_src_o(wr_reg_d_src), .db_data_src_o(db_data_src),
    .m_rd_o(m_rd), .m_wr_o(m_wr), .pc_src_o(pc_src),
    .illegal_op_o(illegal_op), .state_o(state)
  );

  always #5 clk = ~clk;

  typedef enum {
    I_ADD, I_SUB, I_AND, I_OR, I_SLT, I_SLL, I_JR, I_ADDIU, I_ANDI, I_ORI,
    I_XORI, I_SLTI, I_LW, I_SW, I_BEQ, I_BNE, I_J, I_JAL, I_HALT, I_ILL
  } mn_e;

  function automatic mn_e decode(input logic [5:0] o, input logic [5:0] f);
    if (o == 6'b000000) begin
      case (f)
        6'b100000: return I_ADD;
        6'b100010: return I_SUB;
        6'b100100: return I_AND;
        6'b100101: return I_OR;
        6'b101010: return I_SLT;
        6'b000000: return I_SLL;
        6'b001000: return I_JR;
        default:   return I_ILL;
      endcase
    end
    case (o)
      6'b001001: return I_ADDIU;
      6'b001100: return I_ANDI;
      6'b001101: return I_ORI;
      6'b001110: return I_XORI;
      6'b001010: return I_SLTI;
      6'b100011: return I_LW;
      6'b101011: return I_SW;
      6'b000100: return I_BEQ;
      6'b000101: return I_BNE;
      6'b000010: return I_J;
      6'b000011: return I_JAL;
      6'b111111: return I_HALT;
      default:   return I_ILL;
    endcase
  endfunction

  function automatic logic [2:0] alu_of(input mn_e m);
    case (m)
      I_SUB, I_BEQ, I_BNE: return 3'b001;
      I_AND, I_ANDI:       return 3'b010;
      I_OR, I_ORI:         return 3'b011;
      I_SLL:               return 3'b100;
      I_SLT, I_SLTI:       return 3'b101;
      I_XORI:              return 3'b111;
      default:             return 3'b000;
    endcase
  endfunction

  function automatic bit is_alu(input mn_e m);
    return m inside {I_ADD, I_SUB, I_AND, I_OR, I_SLT, I_SLL,
                     I_ADDIU, I_ANDI, I_ORI, I_XORI, I_SLTI};
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected sequence of debug state codes for one instruction.
  function automatic void path_of(input mn_e m, output int p[$]);
    p = {};
    if (is_alu(m))                 p = {0, 1, 6, 7};
    else if (m == I_LW)            p = {0, 1, 2, 3, 4};
    else if (m == I_SW)            p = {0, 1, 2, 3};
    else if (m inside {I_BEQ, I_BNE}) p = {0, 1, 5};
    else                           p = {0, 1};
  endfunction

  // Runs up to max_steps cycles of one instruction; zmode 0/1 fixes zero, 2 randomizes.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int zmode,
                           input int max_steps);
    mn_e m = decode(o, f);
    int  p[$];
    int  n;
    path_of(m, p);
    n = p.size();
    for (int k = 0; k < n && k < max_steps; k++) begin
      int  s = p[k];
      bit  last = (k == n - 1) && (m != I_HALT);
      bit  wr_state = (s == 7) || (s == 4) || (s == 1 && m == I_JAL);
      logic [1:0] epc;
      op = o; funct = f;
      zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
      #1;
      case (m)
        I_J, I_JAL: epc = 2'b11;
        I_JR:       epc = 2'b10;
        I_BEQ:      epc = zero ? 2'b01 : 2'b00;
        I_BNE:      epc = zero ? 2'b00 : 2'b01;
        default:    epc = 2'b00;
      endcase
      chk($sformatf("%s.state%0d", m.name(), k), 8'(state), 8'(s));
      chk("pc_wre", 8'(pc_wre), 8'(last));
      chk("ir_wre", 8'(ir_wre), 8'(s == 0));
      chk("ins_mem_rw", 8'(ins_mem_rw), 8'(s == 0));
      chk("m_rd", 8'(m_rd), 8'(s == 3 && m == I_LW));
      chk("m_wr", 8'(m_wr), 8'(s == 3 && m == I_SW));
      chk("reg_wre", 8'(reg_wre), 8'(wr_state));
      chk("illegal_op", 8'(illegal_op), 8'(s == 1 && m == I_ILL));
      chk("alu_ctr", 8'(alu_ctr), 8'(alu_of(m)));
      chk("alu_src_a", 8'(alu_src_a), 8'(m == I_SLL));
      chk("alu_src_b", 8'(alu_src_b),
          8'(m inside {I_ADDIU, I_ANDI, I_ORI, I_XORI, I_SLTI, I_LW, I_SW}));
      chk("ext_sel", 8'(ext_sel), 8'(!(m inside {I_ANDI, I_ORI, I_XORI})));
      chk("pc_src", 8'(pc_src), 8'(epc));
      if (s == 7) begin
        chk("wbal.reg_dst", 8'(reg_dst), (o == 6'b000000) ? 8'd2 : 8'd1);
        chk("wbal.wr_src", 8'(wr_reg_d_src), 8'd1);
      end else if (s == 4) begin
        chk("wbl.reg_dst", 8'(reg_dst), 8'd1);
        chk("wbl.wr_src", 8'(wr_reg_d_src), 8'd1);
        chk("wbl.db_src", 8'(db_data_src), 8'd1);
      end else if (wr_state) begin
        chk("jal.reg_dst", 8'(reg_dst), 8'd0);
        chk("jal.wr_src", 8'(wr_reg_d_src), 8'd0);
      end
      @(posedge clk); #1;
    end
  endtask

  logic [5:0] legal_op [17] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
    6'b001001, 6'b001100, 6'b001101, 6'b001110, 6'b001010, 6'b100011, 6'b101011,
    6'b000100, 6'b000101, 6'b000010};
  logic [5:0] legal_fn [17] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
    6'b101010, 6'b000000, 6'b001000, 6'h15, 6'h2a, 6'h3f, 6'h01, 6'h10, 6'h05,
    6'h07, 6'h11, 6'h22, 6'h33};

  initial begin
    logic [5:0] ro, rf;
    rst_n = 1'b0; op = 6'b100011; funct = 6'h00; zero = 1'b0;
    // Reset low for two edges: enables masked, state parks in IF.
    @(posedge clk); #1;
    chk("rst.state", 8'(state), 8'd0);
    chk("rst.ir_wre", 8'(ir_wre), 8'd0);
    chk("rst.pc_wre", 8'(pc_wre), 8'd0);
    @(posedge clk); #1;
    chk("rst.reg_wre", 8'(reg_wre), 8'd0);
    rst_n = 1'b1;
    #1;
    chk("post_rst.state", 8'(state), 8'd0);
    chk("post_rst.ir_wre", 8'(ir_wre), 8'd1);
    @(posedge clk); #1;
    chk("post_rst.id", 8'(state), 8'd1);
    // Resynchronise by resetting again so the first instruction starts in IF.
    rst_n = 1'b0; @(posedge clk); #1; rst_n = 1'b1;

    run_instr(6'b100011, 6'h00, 0, 99);       // lw
    run_instr(6'b000000, 6'b100010, 0, 99);   // sub
    run_instr(6'b000100, 6'h00, 1, 99);       // beq taken
    run_instr(6'b000100, 6'h00, 0, 99);       // beq not taken
    run_instr(6'b000101, 6'h00, 0, 99);       // bne taken
    run_instr(6'b000011, 6'h00, 2, 99);       // jal
    run_instr(6'b000000, 6'b001000, 2, 99);   // jr
    run_instr(6'b001101, 6'h00, 2, 99);       // ori
    run_instr(6'b011111, 6'h00, 2, 99);       // illegal opcode
    run_instr(6'b000000, 6'b000000, 2, 99);   // nop (sll)
    run_instr(6'b000000, 6'b111111, 2, 99);   // illegal funct

    for (int i = 0; i < 60; i++) begin
      int sel = int'($urandom_range(0, 19));
      if (sel < 17) begin
        ro = legal_op[sel]; rf = legal_fn[sel];
        if (ro != 6'h00) rf = 6'($urandom);
      end else if (sel == 17) begin
        ro = 6'h00; rf = 6'($urandom);
      end else begin
        ro = 6'($urandom);
        rf = 6'($urandom);
      end
      if (ro == 6'b111111) ro = 6'b011111;
      run_instr(ro, rf, 2, 99);
    end

    // Reset while sw sits in MEM: write suppressed, back to IF.
    run_instr(6'b101011, 6'h00, 2, 3);
    rst_n = 1'b0; #1;
    chk("swrst.state", 8'(state), 8'd3);
    chk("swrst.m_wr", 8'(m_wr), 8'd0);
    chk("swrst.pc_wre", 8'(pc_wre), 8'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; #1;
    chk("swrst.to_if", 8'(state), 8'd0);
    run_instr(6'b101011, 6'h00, 2, 99);

    // Halt: parks with state shown as 000 and no PC write.
    run_instr(6'b111111, 6'h00, 2, 99);
    for (int i = 0; i < 20; i++) begin
      zero = 1'($urandom_range(0, 1)); #1;
      chk("halt.state", 8'(state), 8'd0);
      chk("halt.pc_wre", 8'(pc_wre), 8'd0);
      chk("halt.ir_wre", 8'(ir_wre), 8'd0);
      @(posedge clk); #1;
    end
    rst_n = 1'b0; @(posedge clk); #1; rst_n = 1'b1;
    run_instr(6'b100011, 6'h00, 2, 99);
    run_instr(6'b001110, 6'h00, 2, 99);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
